unscript_data_sender: RTL and testbench
=======================================

// Module: unscript_data_sender
// PURPOSE
//  Board-to-host half of the unscripted-mode UART link. Samples 4 command bits
//  (switches/buttons), packs them as {2'b00, cmd[3:0], 2'b01}, and serialises
//  the byte 8N1, LSB first, on uart_tx. The host decodes bits[1:0]==2'b01 as
//  unscripted mode and bits[5:2] as the payload. Sits between board I/O and the tx pin.
// PARAMETERS
//  CLK_FREQ          100_000_000  system clock frequency, Hz
//  BAUD              9600         line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer, >=2)
//  HEARTBEAT_CYCLES  50_000_000   resend period in clk cycles (used only with UNSCRIPT_HEARTBEAT_EN)
// PORTS
//  clk            in   1  system clock
//  rst            in   1  synchronous reset, active high
//  mode_unscript  in   1  1 = link active, frames may start; 0 = no new frames
//  cmd_in         in   4  asynchronous command bits, payload source
//  send_req       in   1  1-cycle pulse: force a send of the current cmd
//  uart_tx        out  1  serial line, idle high
//  busy           out  1  high from start-bit cycle through the last stop-bit cycle
//  frame_sent     out  1  1-cycle pulse on the final stop-bit cycle
//  last_frame     out  8  byte most recently started
// BEHAVIOUR
//  - Reset: uart_tx=1, busy=0, frame_sent=0, last_frame=8'h00, state=IDLE,
//    pending=0, last_cmd=4'h0, baud and bit counters=0, synchroniser=0.
//  - cmd_in passes through a 2-FF synchroniser -> cmd_s (2-cycle latency).
//  - pending is set when cmd_s != last_cmd, send_req=1, or a heartbeat fires.
//    It stays set across a frame in flight and is cleared only when a frame starts.
//  - FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//    IDLE:  if pending && mode_unscript, latch byte={2'b00,cmd_s,2'b01} into
//           the shift register and last_frame, set last_cmd=cmd_s, clear pending,
//           go to START. uart_tx goes low the next cycle.
//    START: uart_tx=0 for CLKS_PER_BIT cycles.
//    DATA:  8 bits, LSB first, CLKS_PER_BIT cycles each, bit counter 0..7.
//    STOP:  uart_tx=1 for CLKS_PER_BIT cycles. On the last cycle pulse
//           frame_sent, go to IDLE. busy drops on the following cycle.
//  - The baud counter runs 0..CLKS_PER_BIT-1 and resets on every state change.
//    A frame occupies exactly 10*CLKS_PER_BIT cycles with busy=1.
//  - Back-to-back: at least one IDLE cycle (uart_tx=1) between frames.
//  - A cmd change during a frame does not alter the frame in flight.
//    The next frame carries cmd_s sampled at its IDLE launch cycle.
//    Multiple changes during one frame collapse into a single frame.
//  - mode_unscript falling mid-frame: the frame completes normally and pending is held.
//    A held pending launches when mode_unscript returns to 1.
//  - send_req coincident with a launch cycle: the launch consumes it, no extra frame.
//  - rst mid-frame: on the next edge all state returns to reset values and
//    uart_tx=1. The partial frame is abandoned.
// CONFIGURATION
//  UNSCRIPT_HEARTBEAT_EN defined: a free-running counter runs 0..HEARTBEAT_CYCLES-1,
//  and only while mode_unscript=1. At wrap it sets pending, so the host gets a
//  periodic refresh. The counter resets on rst and whenever mode_unscript=0.
//  Not defined: no counter. Frames start only on a cmd change or send_req.
// TESTING  (bench: CLK_FREQ=16, BAUD=1 -> CLKS_PER_BIT=16)
//  1 rst for 3 cycles, then idle -> uart_tx=1, busy=0, last_frame=8'h00, no frame.
//  2 mode=1, cmd_in=4'b1010 -> last_frame=8'h29, line bits 0,1,0,0,1,0,1,0,0,1,
//    each 16 clks; frame_sent once, 160 clks after start.
//  3 send_req pulse with cmd unchanged=4'h3 -> one frame 8'h0D; two pulses during
//    that frame -> exactly one follow-up frame.
//  4 cmd 4'h1->4'h2->4'hF mid-frame -> current frame unchanged, exactly one next
//    frame 8'h3D, >=1 idle-high cycle between frames.
//  5 rst asserted at bit 4 of a frame -> uart_tx=1, busy=0 next cycle, no frame_sent.
//  6 mode=0 with cmd change -> no frame; mode=1 -> frame starts within 1 cycle.
//    With UNSCRIPT_HEARTBEAT_EN and HEARTBEAT_CYCLES=400, unchanged cmd ->
//    frame every 400 clks.

Source files
------------

// File: rtl/unscript_data_sender.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : unscript_data_sender                                            |
// | Desc   : Packs 4 command bits as {2'b00,cmd,2'b01} and sends them 8N1,   |
// |          LSB first. Define UNSCRIPT_HEARTBEAT_EN for a periodic resend.  |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module unscript_data_sender #(
   parameter int CLK_FREQ         = 100_000_000,
   parameter int BAUD             = 9600,
   parameter int HEARTBEAT_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode_unscript,
   input  logic [3:0] cmd_in,
   input  logic       send_req,
   output logic       uart_tx,
   output logic       busy,
   output logic       frame_sent,
   output logic [7:0] last_frame
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t            state_q;
   logic [BAUD_W-1:0] baud_q;
   logic [2:0]        bit_q;
   logic [7:0]        shift_q;
   logic              tx_q;
   logic              busy_q;
   logic              sent_q;
   logic [7:0]        last_frame_q;
   logic [3:0]        last_cmd_q;
   logic              pending_q;
   logic              pending_d;
   logic [3:0]        sync1_q;
   logic [3:0]        cmd_s_q;

   logic              w_launch;
   logic              w_baud_end;
   logic              w_hb_fire;

`ifdef UNSCRIPT_HEARTBEAT_EN
   localparam int HB_W = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
   localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_CYCLES - 1);

   logic [HB_W-1:0] hb_cnt_q;

   assign w_hb_fire = mode_unscript && (hb_cnt_q == HB_LAST);

   // Free-running only while the link is active; held at zero otherwise.
   always_ff @(posedge clk) begin
      if (rst || !mode_unscript) begin
         hb_cnt_q <= '0;
      end else if (hb_cnt_q == HB_LAST) begin
         hb_cnt_q <= '0;
      end else begin
         hb_cnt_q <= hb_cnt_q + HB_W'(1);
      end
   end
`else
   logic w_unused_hb;

   assign w_hb_fire   = 1'b0;
   assign w_unused_hb = (HEARTBEAT_CYCLES != 0);
`endif

   always_comb begin
      w_launch   = (state_q == S_IDLE) && pending_q && mode_unscript;
      w_baud_end = (baud_q == BAUD_LAST);
      pending_d  = pending_q | (cmd_s_q != last_cmd_q) | send_req | w_hb_fire;
      // A launch consumes every request seen in the same cycle.
      if (w_launch) begin
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         baud_q       <= '0;
         bit_q        <= 3'd0;
         shift_q      <= 8'h00;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         sent_q       <= 1'b0;
         last_frame_q <= 8'h00;
         last_cmd_q   <= 4'h0;
         pending_q    <= 1'b0;
         sync1_q      <= 4'h0;
         cmd_s_q      <= 4'h0;
      end else begin
         sync1_q   <= cmd_in;
         cmd_s_q   <= sync1_q;
         pending_q <= pending_d;
         sent_q    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (w_launch) begin
                  shift_q      <= {2'b00, cmd_s_q, 2'b01};
                  last_frame_q <= {2'b00, cmd_s_q, 2'b01};
                  last_cmd_q   <= cmd_s_q;
                  tx_q         <= 1'b0;
                  busy_q       <= 1'b1;
                  baud_q       <= '0;
                  bit_q        <= 3'd0;
                  state_q      <= S_START;
               end
            end
            S_START: begin
               if (w_baud_end) begin
                  baud_q  <= '0;
                  tx_q    <= shift_q[0];
                  shift_q <= {1'b0, shift_q[7:1]};
                  state_q <= S_DATA;
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            S_DATA: begin
               if (w_baud_end) begin
                  baud_q <= '0;
                  if (bit_q == 3'd7) begin
                     bit_q   <= 3'd0;
                     tx_q    <= 1'b1;
                     state_q <= S_STOP;
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                     tx_q    <= shift_q[0];
                     shift_q <= {1'b0, shift_q[7:1]};
                  end
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            S_STOP: begin
               // Registered pulse lands on the final stop-bit cycle.
               if (baud_q == BAUD_PRE) begin
                  sent_q <= 1'b1;
               end
               if (w_baud_end) begin
                  baud_q  <= '0;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign uart_tx    = tx_q;
   assign busy       = busy_q;
   assign frame_sent = sent_q;
   assign last_frame = last_frame_q;

endmodule
`default_nettype wire

// File: tb/tb_unscript_data_sender.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_unscript_data_sender                                         |
// | Desc   : Randomised bench; a line monitor decodes frames for comparison. |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_unscript_data_sender;

   localparam int CPB       = 16;
   localparam int FRAME_LEN = 10 * CPB;

   logic       clk = 1'b0;
   logic       rst;
   logic       mode_unscript;
   logic [3:0] cmd_in;
   logic       send_req;
   logic       uart_tx;
   logic       busy;
   logic       frame_sent;
   logic [7:0] last_frame;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [9:0] bits;
      int         len;
      int         fs_pos;
      int         fs_cnt;
      logic [7:0] lf;
      int         gap;
      int         unstable;
   } frame_t;

   frame_t     frames[$];
   int         idle_low = 0;
   int         stray_fs = 0;
   logic [3:0] cur_cmd;

   unscript_data_sender #(
      .CLK_FREQ(16),
      .BAUD(1),
      .HEARTBEAT_CYCLES(400)
   ) dut (
      .clk(clk),
      .rst(rst),
      .mode_unscript(mode_unscript),
      .cmd_in(cmd_in),
      .send_req(send_req),
      .uart_tx(uart_tx),
      .busy(busy),
      .frame_sent(frame_sent),
      .last_frame(last_frame)
   );

   always #5 clk = ~clk;

   // Byte the host should see for a command: payload in bits 5:2, tag 01.
   function automatic logic [7:0] exp_byte(input logic [3:0] c);
      int v;
      v = int'(c) * 4 + 1;
      return 8'(v);
   endfunction

   // Line bits in time order: start 0, data LSB first, stop 1.
   function automatic logic [9:0] exp_line(input logic [7:0] b);
      logic [9:0] l;
      l[0] = 1'b0;
      for (int i = 0; i < 8; i++) l[i+1] = b[i];
      l[9] = 1'b1;
      return l;
   endfunction

   function automatic logic [3:0] pick_other(input logic [3:0] avoid, input bit no_zero);
      logic [3:0] v;
      do begin
         v = 4'($urandom_range(15, 0));
      end while (v == avoid || (no_zero && v == 4'h0));
      return v;
   endfunction

   initial begin : monitor
      frame_t cur;
      bit     in_frame = 1'b0;
      int     idle_cnt = 1000;
      logic   prev_tx  = 1'b1;
      @(posedge clk);
      forever begin
         @(negedge clk);
         if (busy === 1'b1) begin
            if (!in_frame) begin
               in_frame     = 1'b1;
               cur.bits     = '0;
               cur.len      = 0;
               cur.fs_pos   = -1;
               cur.fs_cnt   = 0;
               cur.lf       = last_frame;
               cur.gap      = idle_cnt;
               cur.unstable = 0;
               idle_cnt     = 0;
            end else if ((cur.len % CPB) != 0 && uart_tx !== prev_tx) begin
               cur.unstable++;
            end
            if ((cur.len % CPB) == CPB / 2 && cur.len < FRAME_LEN)
               cur.bits[cur.len / CPB] = uart_tx;
            if (frame_sent === 1'b1) begin
               cur.fs_cnt++;
               cur.fs_pos = cur.len;
            end
            cur.len++;
         end else begin
            if (in_frame) begin
               frames.push_back(cur);
               in_frame = 1'b0;
            end
            idle_cnt++;
            if (uart_tx !== 1'b1) idle_low++;
            if (frame_sent === 1'b1) stray_fs++;
         end
         prev_tx = uart_tx;
      end
   end

   initial begin : watchdog
      #(60000 * 10);
      $display("FAIL watchdog: simulation exceeded 60000 cycles");
      $fatal(1, "watchdog expired");
   end

   task automatic wait_frames(input int n, input int budget, output bit ok);
      int c = 0;
      while (frames.size() < n && c < budget) begin
         @(posedge clk);
         c++;
      end
      #1;
      ok = (frames.size() >= n);
   endtask

   task automatic wait_busy(input int budget, output bit ok);
      int c = 0;
      @(negedge clk);
      while (busy !== 1'b1 && c < budget) begin
         @(negedge clk);
         c++;
      end
      ok = (busy === 1'b1);
   endtask

   task automatic wait_sent(input int budget, output bit ok);
      int c = 0;
      @(negedge clk);
      while (frame_sent !== 1'b1 && c < budget) begin
         @(negedge clk);
         c++;
      end
      ok = (frame_sent === 1'b1);
   endtask

   task automatic test_reset();
      rst = 1'b1; mode_unscript = 1'b0; send_req = 1'b0; cmd_in = 4'h0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (frame_sent !== 1'b0) begin errors++; $display("FAIL reset_sent: got %b want 0", frame_sent); end
      checks++; if (last_frame !== 8'h00) begin errors++; $display("FAIL reset_last_frame: got %h want 00", last_frame); end
      checks++; if (frames.size() != 0) begin errors++; $display("FAIL reset_no_frame: got %0d frames want 0", frames.size()); end
      cur_cmd = 4'h0;
   endtask

   task automatic test_single_frame();
      int     base = frames.size();
      bit     ok;
      frame_t f;
      @(posedge clk); #1;
      mode_unscript = 1'b1;
      cmd_in = 4'b1010;
      wait_frames(base + 1, 400, ok);
      checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got %0d frames want %0d", frames.size(), base + 1); end
      else begin
         f = frames[base];
         checks++; if (f.bits !== exp_line(exp_byte(4'hA))) begin errors++; $display("FAIL single_line: got %b want %b", f.bits, exp_line(exp_byte(4'hA))); end
         checks++; if (f.len != FRAME_LEN || f.unstable != 0) begin errors++; $display("FAIL single_timing: got len %0d unstable %0d want %0d 0", f.len, f.unstable, FRAME_LEN); end
         checks++; if (f.fs_cnt != 1 || f.fs_pos != FRAME_LEN - 1) begin errors++; $display("FAIL single_sent: got cnt %0d pos %0d want 1 %0d", f.fs_cnt, f.fs_pos, FRAME_LEN - 1); end
         checks++; if (last_frame !== exp_byte(4'hA)) begin errors++; $display("FAIL single_last_frame: got %h want %h", last_frame, exp_byte(4'hA)); end
      end
      cur_cmd = 4'hA;
      for (int i = 0; i < 3; i++) begin
         logic [3:0] c;
         c = pick_other(cur_cmd, 1'b0);
         @(posedge clk); #1;
         cmd_in = c;
         wait_frames(base + 2 + i, 400, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL rand_timeout: got %0d frames want %0d", frames.size(), base + 2 + i); end
         else if (frames[base+1+i].bits !== exp_line(exp_byte(c)) || frames[base+1+i].len != FRAME_LEN ||
                  frames[base+1+i].lf !== exp_byte(c)) begin
            errors++;
            $display("FAIL rand_frame: got line %b len %0d lf %h want %b %0d %h", frames[base+1+i].bits,
                     frames[base+1+i].len, frames[base+1+i].lf, exp_line(exp_byte(c)), FRAME_LEN, exp_byte(c));
         end
         cur_cmd = c;
      end
      repeat (200) @(posedge clk);
      #1;
      checks++; if (frames.size() != base + 4) begin errors++; $display("FAIL single_quiet: got %0d frames want %0d", frames.size(), base + 4); end
   endtask

   task automatic test_send_req();
      int base;
      bit ok;
      @(posedge clk); #1;
      cmd_in = 4'h3;
      wait_frames(frames.size() + 1, 400, ok);
      cur_cmd = 4'h3;
      base = frames.size();
      repeat (10) @(posedge clk);
      #1 send_req = 1'b1;
      @(posedge clk); #1 send_req = 1'b0;
      wait_busy(20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL req_start: got busy %b want 1", busy); end
      repeat ($urandom_range(50, 10)) @(posedge clk);
      #1 send_req = 1'b1;
      @(posedge clk); #1 send_req = 1'b0;
      repeat ($urandom_range(50, 10)) @(posedge clk);
      #1 send_req = 1'b1;
      @(posedge clk); #1 send_req = 1'b0;
      wait_sent(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL req_sent_timeout: got frame_sent %b want 1", frame_sent); end
      // Request in the idle cycle that also launches the follow-up frame.
      @(posedge clk); #1 send_req = 1'b1;
      @(posedge clk); #1 send_req = 1'b0;
      wait_frames(base + 2, 400, ok);
      repeat (300) @(posedge clk);
      #1;
      checks++; if (frames.size() != base + 2) begin errors++; $display("FAIL req_count: got %0d frames want %0d", frames.size(), base + 2); end
      if (frames.size() >= base + 2) begin
         checks++; if (frames[base].bits !== exp_line(exp_byte(4'h3)) || frames[base+1].bits !== exp_line(exp_byte(4'h3))) begin
            errors++; $display("FAIL req_bytes: got %b %b want %b", frames[base].bits, frames[base+1].bits, exp_line(exp_byte(4'h3))); end
         checks++; if (frames[base+1].gap < 1 || frames[base+1].len != FRAME_LEN) begin
            errors++; $display("FAIL req_gap: got gap %0d len %0d want >=1 %0d", frames[base+1].gap, frames[base+1].len, FRAME_LEN); end
      end
   endtask

   task automatic test_cmd_change();
      logic [3:0] seq [4];
      logic [3:0] first;
      int         base;
      bit         ok;
      for (int round = 0; round < 2; round++) begin
         if (round == 0) begin
            seq[0] = 4'h1; seq[1] = 4'h2; seq[2] = 4'h2; seq[3] = 4'hF;
         end else begin
            seq[0] = pick_other(cur_cmd, 1'b0);
            seq[1] = 4'($urandom_range(15, 0));
            seq[2] = 4'($urandom_range(15, 0));
            seq[3] = pick_other(seq[0], 1'b0);
         end
         first = seq[0];
         base = frames.size();
         @(posedge clk); #1 cmd_in = first;
         wait_busy(20, ok);
         for (int k = 1; k < 4; k++) begin
            repeat ($urandom_range(35, 5)) @(posedge clk);
            #1 cmd_in = seq[k];
         end
         wait_frames(base + 2, 600, ok);
         repeat (300) @(posedge clk);
         #1;
         checks++; if (frames.size() != base + 2) begin errors++; $display("FAIL chg_count: got %0d frames want %0d", frames.size(), base + 2); end
         if (frames.size() >= base + 2) begin
            checks++; if (frames[base].bits !== exp_line(exp_byte(first))) begin
               errors++; $display("FAIL chg_inflight: got %b want %b", frames[base].bits, exp_line(exp_byte(first))); end
            checks++; if (frames[base+1].bits !== exp_line(exp_byte(seq[3])) || frames[base+1].gap < 1) begin
               errors++; $display("FAIL chg_next: got %b gap %0d want %b gap>=1", frames[base+1].bits, frames[base+1].gap, exp_line(exp_byte(seq[3]))); end
         end
         cur_cmd = seq[3];
      end
   endtask

   task automatic test_reset_midframe();
      logic [3:0] c;
      int         base = frames.size();
      bit         ok;
      c = pick_other(cur_cmd, 1'b1);
      @(posedge clk); #1 cmd_in = c;
      wait_busy(20, ok);
      // Land the reset edge inside data bit 4.
      repeat (85) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (uart_tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_line: got tx %b busy %b want 1 0", uart_tx, busy); end
      checks++; if (last_frame !== 8'h00) begin errors++; $display("FAIL rst_mid_last_frame: got %h want 00", last_frame); end
      wait_frames(base + 2, 400, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rst_mid_timeout: got %0d frames want %0d", frames.size(), base + 2); end
      else begin
         checks++; if (frames[base].fs_cnt != 0 || frames[base].len >= FRAME_LEN) begin
            errors++; $display("FAIL rst_mid_abort: got sent %0d len %0d want 0 <%0d", frames[base].fs_cnt, frames[base].len, FRAME_LEN); end
         checks++; if (frames[base+1].bits !== exp_line(exp_byte(c)) || frames[base+1].len != FRAME_LEN) begin
            errors++; $display("FAIL rst_mid_resend: got %b len %0d want %b %0d", frames[base+1].bits, frames[base+1].len, exp_line(exp_byte(c)), FRAME_LEN); end
      end
      cur_cmd = c;
   endtask

   task automatic test_mode_gate();
      logic [3:0] c, c2, c3;
      int         base = frames.size();
      bit         ok;
      c = pick_other(cur_cmd, 1'b0);
      @(posedge clk); #1;
      mode_unscript = 1'b0;
      cmd_in = c;
      repeat (100) @(posedge clk);
      @(negedge clk);
      checks++; if (frames.size() != base || uart_tx !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL mode_off: got frames %0d tx %b busy %b want %0d 1 0", frames.size(), uart_tx, busy, base); end
      @(posedge clk); #1 mode_unscript = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mode_resume_start: got busy %b want 1", busy); end
      wait_frames(base + 1, 400, ok);
      checks++; if (!ok || frames[base].bits !== exp_line(exp_byte(c))) begin
         errors++; $display("FAIL mode_resume_frame: got %0d frames want %b", frames.size(), exp_line(exp_byte(c))); end
      c2 = pick_other(c, 1'b0);
      c3 = pick_other(c2, 1'b0);
      @(posedge clk); #1 cmd_in = c2;
      wait_busy(20, ok);
      repeat (40) @(posedge clk);
      #1 mode_unscript = 1'b0;
      cmd_in = c3;
      wait_frames(base + 2, 400, ok);
      repeat (100) @(posedge clk);
      #1;
      checks++; if (frames.size() != base + 2) begin errors++; $display("FAIL mode_drop_count: got %0d frames want %0d", frames.size(), base + 2); end
      else begin
         checks++; if (frames[base+1].bits !== exp_line(exp_byte(c2)) || frames[base+1].len != FRAME_LEN) begin
            errors++; $display("FAIL mode_drop_frame: got %b len %0d want %b %0d", frames[base+1].bits, frames[base+1].len, exp_line(exp_byte(c2)), FRAME_LEN); end
      end
      mode_unscript = 1'b1;
      wait_frames(base + 3, 400, ok);
      checks++; if (!ok || frames[base+2].bits !== exp_line(exp_byte(c3))) begin
         errors++; $display("FAIL mode_held_pending: got %0d frames want %b", frames.size(), exp_line(exp_byte(c3))); end
      cur_cmd = c3;
   endtask

   task automatic test_quiet();
      int base = frames.size();
      repeat (1000) @(posedge clk);
      #1;
      checks++; if (frames.size() != base) begin errors++; $display("FAIL quiet_no_frame: got %0d frames want %0d", frames.size(), base); end
   endtask

   task automatic test_line_integrity();
      checks++; if (idle_low != 0) begin errors++; $display("FAIL idle_line: got %0d low idle cycles want 0", idle_low); end
      checks++; if (stray_fs != 0) begin errors++; $display("FAIL stray_sent: got %0d pulses outside busy want 0", stray_fs); end
   endtask

   initial begin
      rst = 1'b1; mode_unscript = 1'b0; send_req = 1'b0; cmd_in = 4'h0;
      test_reset();
      test_single_frame();
      test_send_req();
      test_cmd_change();
      test_reset_midframe();
      test_mode_gate();
      test_quiet();
      test_line_integrity();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
